// File: rtl/hazard_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_ctrl
// Brief    : ID-stage interlock for an in-order 5-stage pipeline. Keeps a
//            per-register countdown of in-flight writes plus a multiplier
//            occupancy counter, and holds IF/ID / bubbles EX on hazards.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_ctrl #(
    parameter int NREG    = 32,
    parameter int LAT_ALU = 3,
    parameter int LAT_MUL = 5,
    parameter int MUL_OCC = 4,
    parameter int CW      = $clog2(LAT_MUL + 1)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic            id_rs1_used,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs2_used,
    input  logic [4:0]      id_rd,
    input  logic            id_rd_wr,
    input  logic            id_is_mul,
    input  logic            flush,
    output logic            if_stall,
    output logic            id_issue,
    output logic            ex_bubble,
    output logic            hazard_raw,
    output logic            hazard_mul,
    output logic [NREG-1:0] busy_mask,
    output logic [31:0]     stall_count
);

    // Multiplier counter only needs to hold MUL_OCC-1; keep at least one bit.
    localparam int            c_mul_w   = (MUL_OCC > 1) ? $clog2(MUL_OCC) : 1;
    localparam logic [CW-1:0] c_lat_alu = CW'(LAT_ALU);
    localparam logic [CW-1:0] c_lat_mul = CW'(LAT_MUL);
    localparam logic [c_mul_w-1:0] c_mul_load = c_mul_w'(MUL_OCC - 1);

    logic [NREG-1:0]    w_busy;
    logic [c_mul_w-1:0] r_mul_cnt;
    logic [31:0]        r_stall_count;
    logic               w_raw;
    logic               w_mul;
    logic               w_stall;
    logic               w_issue;

    // x0 is hard-wired, so it never carries a pending write.
    assign w_busy[0] = 1'b0;

    // One countdown per architectural register; loaded on issue of a writer.
    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [CW-1:0] r_cnt;

        // Load latency on issue of a writer to this register, else count down.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_cnt <= '0;
            end else if (w_issue && id_rd_wr && (id_rd == 5'(r))) begin
                r_cnt <= id_is_mul ? c_lat_mul : c_lat_alu;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end

        assign w_busy[r] = (r_cnt != '0);
    end

    // RAW on either source, plus conservative WAW on the destination.
    always_comb begin
        w_raw = 1'b0;
        if (id_valid) begin
            w_raw = (id_rs1_used && (id_rs1 != 5'd0) && w_busy[id_rs1]) ||
                    (id_rs2_used && (id_rs2 != 5'd0) && w_busy[id_rs2]) ||
                    (id_rd_wr    && (id_rd  != 5'd0) && w_busy[id_rd]);
        end
    end

    assign w_mul   = id_valid && id_is_mul && (r_mul_cnt != '0);
    // A flush kills the ID instruction, so there is nothing left to hold.
    assign w_stall = (w_raw || w_mul) && !flush;
    assign w_issue = id_valid && !w_stall && !flush;

    // Multiplier occupancy: reload on each issued MUL, otherwise drain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mul_cnt <= '0;
        end else if (w_issue && id_is_mul) begin
            r_mul_cnt <= c_mul_load;
        end else if (r_mul_cnt != '0) begin
            r_mul_cnt <= r_mul_cnt - 1'b1;
        end
    end

    // Saturating count of stalled cycles for performance monitoring.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign if_stall    = w_stall;
    assign id_issue    = w_issue;
    assign ex_bubble   = !w_issue;
    assign hazard_raw  = w_raw;
    assign hazard_mul  = w_mul;
    assign busy_mask   = w_busy;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire
